// File: rtl/click_classifier_pkg.sv
// Shared types and helpers for the click classifier.
//   - state_e     : FSM state encoding (ST_IDLE / ST_COUNT)
//   - EVT_TOTAL_W : width of the optional event statistics counter
//   - clog2       : ceiling log2, used for the click-count and timer widths
package click_classifier_pkg;

    localparam int unsigned EVT_TOTAL_W = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_e;

    // Smallest r such that 2**r >= v (returns 0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/click_classifier_window_timer.sv
// Inter-click window counter.
//   clk, rst_n   : clock, async active-low reset
//   restart_i    : clear the count to zero (has priority)
//   enable_i     : advance the count by one
//   terminal_c_o : combinational flag, count == TERMINAL
// The count parks at TERMINAL, so it can never wrap.
module window_timer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TERMINAL = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    input  logic enable_i,
    output logic terminal_c_o
);

    logic [WIDTH-1:0] count_q;

    assign terminal_c_o = (count_q == WIDTH'(TERMINAL));

    // Restartable up-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (restart_i) begin
            count_q <= '0;
        end else if (enable_i && !terminal_c_o) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/click_classifier.sv
// Groups debounced press pulses into bursts and reports one event per burst.
// A burst ends when no new press arrives within WINDOW_CYCLES.
//   clk, rst_n    : clock, async active-low reset
//   press_pulse   : debounced press (a multi-cycle high counts once)
//   evt_valid     : one-cycle pulse, burst finished
//   evt_clicks    : clicks in the finished burst (saturates at MAX_CLICKS), held
//   evt_overflow  : burst exceeded MAX_CLICKS, held
//   busy          : burst in progress (combinational from the state register)
//   evt_total     : saturating count of emitted events
//                   (present only when CLICK_CLASSIFIER_STATS_EN is defined)
import click_classifier_pkg::*;

module click_classifier #(
    parameter int unsigned WINDOW_CYCLES = 5000000,
    parameter int unsigned MAX_CLICKS    = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                press_pulse,
    output logic                                evt_valid,
    output logic [clog2(MAX_CLICKS + 1)-1:0]    evt_clicks,
    output logic                                evt_overflow,
    output logic                                busy
`ifdef CLICK_CLASSIFIER_STATS_EN
    ,
    output logic [EVT_TOTAL_W-1:0]              evt_total
`endif
);

    localparam int unsigned CNT_W   = clog2(MAX_CLICKS + 1);
    localparam int unsigned TIMER_W = clog2(WINDOW_CYCLES);

    state_e             state_q;
    logic               prev_q;
    logic [CNT_W-1:0]   clicks_q;
    logic               ovf_q;
    logic               evt_valid_q;
    logic [CNT_W-1:0]   evt_clicks_q;
    logic               evt_overflow_q;

    logic               press_c;
    logic               tmr_term_c;
    logic               expire_c;
    logic               tmr_restart_c;

    // Rising-edge detect so a held press is only counted once.
    assign press_c  = press_pulse & ~prev_q;
    // A press on the terminal cycle wins: the window restarts instead.
    assign expire_c = (state_q == ST_COUNT) & tmr_term_c & ~press_c;
    assign tmr_restart_c = press_c | expire_c | (state_q == ST_IDLE);

    assign busy         = (state_q == ST_COUNT);
    assign evt_valid    = evt_valid_q;
    assign evt_clicks   = evt_clicks_q;
    assign evt_overflow = evt_overflow_q;

    window_timer #(
        .WIDTH    (TIMER_W),
        .TERMINAL (WINDOW_CYCLES - 1)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart_i    (tmr_restart_c),
        .enable_i     (state_q == ST_COUNT),
        .terminal_c_o (tmr_term_c)
    );

    // Burst FSM, click/overflow tracking and registered event outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            prev_q         <= 1'b0;
            clicks_q       <= '0;
            ovf_q          <= 1'b0;
            evt_valid_q    <= 1'b0;
            evt_clicks_q   <= '0;
            evt_overflow_q <= 1'b0;
        end else begin
            prev_q      <= press_pulse;
            evt_valid_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (press_c) begin
                    state_q  <= ST_COUNT;
                    clicks_q <= CNT_W'(1);
                    ovf_q    <= 1'b0;
                end
            end else begin
                if (press_c) begin
                    if (clicks_q < CNT_W'(MAX_CLICKS)) begin
                        clicks_q <= clicks_q + CNT_W'(1);
                    end else begin
                        ovf_q <= 1'b1;
                    end
                end else if (expire_c) begin
                    evt_valid_q    <= 1'b1;
                    evt_clicks_q   <= clicks_q;
                    evt_overflow_q <= ovf_q;
                    state_q        <= ST_IDLE;
                end
            end
        end
    end

`ifdef CLICK_CLASSIFIER_STATS_EN
    logic [EVT_TOTAL_W-1:0] evt_total_q;

    assign evt_total = evt_total_q;

    // Saturating count of emitted events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_total_q <= '0;
        end else if (expire_c && (evt_total_q != {EVT_TOTAL_W{1'b1}})) begin
            evt_total_q <= evt_total_q + EVT_TOTAL_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_click_classifier.sv
// Scoreboard bench for click_classifier (WINDOW_CYCLES=8, MAX_CLICKS=3).
// Expected events are queued when a burst is driven and checked by a
// monitor when evt_valid rises. Define CLICK_CLASSIFIER_STATS_EN to also
// exercise evt_total.
module tb_click_classifier;

    localparam int unsigned WIN   = 8;
    localparam int unsigned MAXC  = 3;
    localparam int unsigned CNT_W = 2;

    typedef struct {
        int clicks;
        bit ovf;
        int cyc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             press_pulse;
    logic             evt_valid;
    logic [CNT_W-1:0] evt_clicks;
    logic             evt_overflow;
    logic             busy;
`ifdef CLICK_CLASSIFIER_STATS_EN
    logic [15:0]      evt_total;
`endif

    exp_t q[$];
    int   total;
    int   bad;
    int   cyc;
    int   ev_seen;
    logic prev_valid;

    click_classifier #(
        .WINDOW_CYCLES (WIN),
        .MAX_CLICKS    (MAXC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .press_pulse  (press_pulse),
        .evt_valid    (evt_valid),
        .evt_clicks   (evt_clicks),
        .evt_overflow (evt_overflow),
        .busy         (busy)
`ifdef CLICK_CLASSIFIER_STATS_EN
        ,
        .evt_total    (evt_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: pops one expectation per observed event.
    initial begin
        prev_valid = 1'b0;
        ev_seen    = 0;
    end
    always @(negedge clk) begin
        exp_t e;
        if (evt_valid === 1'b1) begin
            ev_seen = ev_seen + 1;
            total = total + 1;
            if (q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_event at cyc=%0d clicks=%0d ovf=%0b", cyc, evt_clicks, evt_overflow);
            end else begin
                e = q.pop_front();
                if (evt_clicks !== CNT_W'(e.clicks) || evt_overflow !== e.ovf || cyc != e.cyc) begin
                    bad = bad + 1;
                    $display("FAIL event got clicks=%0d ovf=%0b cyc=%0d want clicks=%0d ovf=%0b cyc=%0d",
                             evt_clicks, evt_overflow, cyc, e.clicks, e.ovf, e.cyc);
                end
            end
            total = total + 1;
            if (prev_valid === 1'b1) begin
                bad = bad + 1;
                $display("FAIL evt_valid_consecutive at cyc=%0d got 1 want 0", cyc);
            end
        end
        prev_valid = evt_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Raise press_pulse now (caller is at a negedge) for n cycles; c = cyc at raise.
    task automatic press_for(input int n, output int c);
        c = cyc;
        press_pulse = 1'b1;
        repeat (n) @(negedge clk);
        press_pulse = 1'b0;
    endtask

    task automatic push_exp(input int clicks, input bit ovf, input int c);
        exp_t e;
        e.clicks = clicks;
        e.ovf    = ovf;
        e.cyc    = c + WIN + 1;
        q.push_back(e);
    endtask

    // Wait (bounded) for the scoreboard queue to empty.
    task automatic wait_drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        if (q.size() != 0) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL %s_drain got pending=%0d want 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        press_pulse = 1'b0;
        repeat (3) @(negedge clk);
        total = total + 1;
        if ({evt_valid, evt_clicks, evt_overflow, busy} !== 5'b0) begin
            bad = bad + 1;
            $display("FAIL reset_outputs got %b want 00000", {evt_valid, evt_clicks, evt_overflow, busy});
        end
`ifdef CLICK_CLASSIFIER_STATS_EN
        total = total + 1;
        if (evt_total !== 16'd0) begin
            bad = bad + 1;
            $display("FAIL reset_evt_total got %0d want 0", evt_total);
        end
`endif
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        total = total + 1;
        if (ev_seen != 0 || busy !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL idle_quiet got events=%0d busy=%b want 0 0", ev_seen, busy);
        end
    endtask

    task automatic test_single();
        int c;
        press_for(1, c);
        push_exp(1, 1'b0, c);
        total = total + 1;
        if (busy !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL single_busy got %b want 1", busy);
        end
        wait_drain("single");
        @(negedge clk);
        total = total + 1;
        if (busy !== 1'b0 || evt_clicks !== 2'd1) begin
            bad = bad + 1;
            $display("FAIL single_after got busy=%b clicks=%0d want 0 1", busy, evt_clicks);
        end
    endtask

    task automatic test_double_held();
        int c;
        press_for(1, c);
        repeat (4) @(negedge clk);
        press_for(4, c);
        push_exp(2, 1'b0, c);
        wait_drain("double");
        repeat (3) @(negedge clk);
    endtask

    task automatic test_overflow();
        int c;
        for (int i = 0; i < 5; i++) begin
            press_for(1, c);
            if (i != 4) repeat (2) @(negedge clk);
        end
        push_exp(3, 1'b1, c);
        wait_drain("overflow");
        repeat (2) @(negedge clk);
        press_for(1, c);
        push_exp(1, 1'b0, c);
        wait_drain("after_overflow");
        total = total + 1;
        if (evt_overflow !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL overflow_clear got %b want 0", evt_overflow);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_terminal_press();
        int c;
        press_for(1, c);
        repeat (WIN - 1) @(negedge clk);
        press_for(1, c);
        total = total + 1;
        if (evt_valid !== 1'b0 || busy !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL terminal_press got valid=%b busy=%b want 0 1", evt_valid, busy);
        end
        push_exp(2, 1'b0, c);
        wait_drain("terminal");
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int c;
        press_for(1, c);
        push_exp(1, 1'b0, c);
        repeat (WIN) @(negedge clk);
        total = total + 1;
        if (evt_valid !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL b2b_first_event got %b want 1", evt_valid);
        end
        press_for(1, c);
        push_exp(1, 1'b0, c);
        total = total + 1;
        if (busy !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL b2b_restart_busy got %b want 1", busy);
        end
        wait_drain("b2b");
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int c;
        int seen0;
        press_for(1, c);
        repeat (3) @(negedge clk);
        total = total + 1;
        if (busy !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL midrst_busy_before got %b want 1", busy);
        end
        seen0 = ev_seen;
        #2 rst_n = 1'b0;
        #1;
        total = total + 1;
        if (busy !== 1'b0 || evt_clicks !== 2'd0) begin
            bad = bad + 1;
            $display("FAIL midrst_async got busy=%b clicks=%0d want 0 0", busy, evt_clicks);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        total = total + 1;
        if (ev_seen != seen0) begin
            bad = bad + 1;
            $display("FAIL midrst_no_event got %0d want %0d", ev_seen - seen0, 0);
        end
`ifdef CLICK_CLASSIFIER_STATS_EN
        for (int i = 0; i < 2; i++) begin
            press_for(1, c);
            push_exp(1, 1'b0, c);
            wait_drain("stats");
            repeat (2) @(negedge clk);
        end
        total = total + 1;
        if (evt_total !== 16'd2) begin
            bad = bad + 1;
            $display("FAIL stats_total got %0d want 2", evt_total);
        end
        #2 rst_n = 1'b0;
        #1;
        total = total + 1;
        if (evt_total !== 16'd0) begin
            bad = bad + 1;
            $display("FAIL stats_reset got %0d want 0", evt_total);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_double_held();
        test_overflow();
        test_terminal_press();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
